// File: rtl/dm_stage_pkg.sv
// Shared types and constants for the data-memory stage.
`timescale 1ns/1ps
package dm_stage_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_e;

   // Lane 0 sits in the most significant byte (big-endian within a word).
   localparam logic LANE_HI = 1'b0;
   localparam logic LANE_LO = 1'b1;

   localparam int WAIT_W = 3;

   function automatic logic [7:0] lane_byte(input logic [15:0] w, input logic lane);
      return (lane == LANE_HI) ? w[15:8] : w[7:0];
   endfunction

endpackage

// File: rtl/dm_ram.sv
// Local data RAM: synchronous byte-lane write, combinational read.
// DMEM_PARITY_EN adds an even-parity bit per word and reports mismatches on read.
`timescale 1ns/1ps
module dm_ram #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] addr,
   input  logic              we_hi,
   input  logic              we_lo,
   input  logic [15:0]       wdata,
   output logic [15:0]       rdata,
   output logic              perr
);

`ifdef DMEM_PARITY_EN
   localparam int DW = 17;
`else
   localparam int DW = 16;
`endif

   logic [DW-1:0] mem_q [2**ADDR_W];
   logic [DW-1:0] rd_word;
   logic [DW-1:0] wr_word;
   logic [15:0]   merged;

   always_comb begin
      rd_word = mem_q[addr];
      rdata   = rd_word[15:0];
      // Byte stores merge with the current word so parity covers the final contents.
      merged  = {we_hi ? wdata[15:8] : rd_word[15:8],
                 we_lo ? wdata[7:0]  : rd_word[7:0]};
`ifdef DMEM_PARITY_EN
      wr_word = {^merged, merged};
      perr    = ^rd_word;
`else
      wr_word = merged;
      perr    = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (we_hi | we_lo) mem_q[addr] <= wr_word;
   end

endmodule

// File: rtl/dm_stage.sv
// Data-memory stage: pass-through or word/byte load/store with WAIT_STATES extra cycles.
// Optional parity checking is enabled with DMEM_PARITY_EN.
`timescale 1ns/1ps
module dm_stage
   import dm_stage_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] alu_res,
   input  logic [15:0] st_data,
   input  logic        mem_rd,
   input  logic        mem_wr,
   input  logic        byte_op,
   output logic [15:0] ans_dm,
   output logic        out_valid,
   output logic        mem_err
);

   state_e            state_q, state_d;
   logic [WAIT_W-1:0] cnt_q, cnt_d;
   logic [15:0]       addr_q, addr_d;
   logic [15:0]       data_q, data_d;
   logic              wr_q, wr_d;
   logic              byte_q, byte_d;
   logic [15:0]       ans_q, ans_d;
   logic              vld_q, vld_d;
   logic              err_q, err_d;

   logic              commit;
   logic              we_hi, we_lo;
   logic [15:0]       ram_wdata, ram_rdata;
   logic              ram_perr;

   assign in_ready  = (state_q == IDLE);
   assign ans_dm    = ans_q;
   assign out_valid = vld_q;
   assign mem_err   = err_q;

   // Gate with reset so an abort on the commit edge never writes the RAM.
   assign commit    = (state_q == ACCESS) && (cnt_q == '0) && reset;
   assign we_hi     = commit && wr_q && (!byte_q || addr_q[0] == LANE_HI);
   assign we_lo     = commit && wr_q && (!byte_q || addr_q[0] == LANE_LO);
   assign ram_wdata = byte_q ? {data_q[7:0], data_q[7:0]} : data_q;

   dm_ram #(.ADDR_W(ADDR_W)) u_ram (
      .clk   (clk),
      .addr  (addr_q[ADDR_W:1]),
      .we_hi (we_hi),
      .we_lo (we_lo),
      .wdata (ram_wdata),
      .rdata (ram_rdata),
      .perr  (ram_perr)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      data_d  = data_q;
      wr_d    = wr_q;
      byte_d  = byte_q;
      ans_d   = ans_q;
      vld_d   = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (mem_rd | mem_wr) begin
                  state_d = ACCESS;
                  cnt_d   = WAIT_W'(WAIT_STATES);
                  addr_d  = alu_res;
                  data_d  = st_data;
                  wr_d    = mem_wr;
                  byte_d  = byte_op;
               end else begin
                  ans_d = alu_res;
                  vld_d = 1'b1;
               end
            end
         end
         ACCESS: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - WAIT_W'(1);
            end else begin
               state_d = IDLE;
               vld_d   = 1'b1;
               if (wr_q) begin
                  ans_d = addr_q;
               end else begin
                  ans_d = byte_q ? {8'h00, lane_byte(ram_rdata, addr_q[0])} : ram_rdata;
                  err_d = ram_perr;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         wr_q    <= 1'b0;
         byte_q  <= 1'b0;
         ans_q   <= '0;
         vld_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         wr_q    <= wr_d;
         byte_q  <= byte_d;
         ans_q   <= ans_d;
         vld_q   <= vld_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_dm_stage.sv
// Directed self-checking bench for dm_stage (ADDR_W=8, WAIT_STATES=1).
`timescale 1ns/1ps
module tb_dm_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] alu_res;
   logic [15:0] st_data;
   logic        mem_rd;
   logic        mem_wr;
   logic        byte_op;
   logic [15:0] ans_dm;
   logic        out_valid;
   logic        mem_err;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   always #5 clk = ~clk;

   dm_stage #(.ADDR_W(8), .WAIT_STATES(1)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_res   (alu_res),
      .st_data   (st_data),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .byte_op   (byte_op),
      .ans_dm    (ans_dm),
      .out_valid (out_valid),
      .mem_err   (mem_err)
   );

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Issue one memory op; in_valid is held through the first ACCESS cycle to show it is ignored.
   // lat = edges from accept to completion, rdy_lo = sampled cycles with in_ready low.
   task automatic mem_op(input logic [15:0] a, input logic [15:0] d, input logic rd,
                         input logic wr, input logic bt, output logic [15:0] ans,
                         output int lat, output int rdy_lo, output logic err);
      in_valid = 1'b1; alu_res = a; st_data = d; mem_rd = rd; mem_wr = wr; byte_op = bt;
      tick();
      lat = 1; rdy_lo = 0;
      while (!out_valid && lat < 20) begin
         if (!in_ready) rdy_lo++;
         if (lat > 1) in_valid = 1'b0;
         tick();
         lat++;
      end
      in_valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; byte_op = 1'b0;
      lat = lat - 1;
      ans = ans_dm;
      err = mem_err;
   endtask

   task automatic test_reset();
      reset = 1'b0; in_valid = 1'b0; alu_res = '0; st_data = '0;
      mem_rd = 1'b0; mem_wr = 1'b0; byte_op = 1'b0;
      @(negedge clk);
      tick(); tick();
      chk_cnt++;
      if (ans_dm !== 16'h0000 || out_valid !== 1'b0 || mem_err !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL reset: ans=%h ov=%b err=%b rdy=%b want 0000/0/0/1",
                  ans_dm, out_valid, mem_err, in_ready);
      else pass_cnt++;
      reset = 1'b1;
   endtask

   task automatic test_passthru();
      in_valid = 1'b1; alu_res = 16'h1234;
      tick();
      chk_cnt++;
      if (ans_dm !== 16'h1234 || out_valid !== 1'b1 || in_ready !== 1'b1)
         $display("FAIL passthru: ans=%h ov=%b rdy=%b want 1234/1/1", ans_dm, out_valid, in_ready);
      else pass_cnt++;
      in_valid = 1'b0; alu_res = 16'hFFFF;
      tick();
      chk_cnt++;
      if (ans_dm !== 16'h1234 || out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL passthru_hold: ans=%h ov=%b rdy=%b want 1234/0/1", ans_dm, out_valid, in_ready);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [15:0] vals [3];
      vals[0] = 16'h0001; vals[1] = 16'h8002; vals[2] = 16'h7FFC;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; alu_res = vals[i];
         tick();
         chk_cnt++;
         if (ans_dm !== vals[i] || out_valid !== 1'b1 || in_ready !== 1'b1)
            $display("FAIL b2b_%0d: ans=%h ov=%b rdy=%b want %h/1/1", i, ans_dm, out_valid, in_ready, vals[i]);
         else pass_cnt++;
      end
      in_valid = 1'b0;
      tick();
   endtask

   task automatic test_word();
      logic [15:0] ans; int lat, rlo; logic err;
      mem_op(16'h0010, 16'hBEEF, 1'b0, 1'b1, 1'b0, ans, lat, rlo, err);
      chk_cnt++;
      if (ans !== 16'h0010 || lat != 2 || rlo != 2)
         $display("FAIL store_word: ans=%h lat=%0d rdylo=%0d want 0010/2/2", ans, lat, rlo);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (out_valid !== 1'b0 || ans_dm !== 16'h0010)
         $display("FAIL ov_pulse: ov=%b ans=%h want 0/0010", out_valid, ans_dm);
      else pass_cnt++;
      mem_op(16'h0010, 16'h0000, 1'b1, 1'b0, 1'b0, ans, lat, rlo, err);
      chk_cnt++;
      if (ans !== 16'hBEEF || lat != 2 || rlo != 2 || err !== 1'b0)
         $display("FAIL load_word: ans=%h lat=%0d rdylo=%0d err=%b want BEEF/2/2/0", ans, lat, rlo, err);
      else pass_cnt++;
   endtask

   task automatic test_byte();
      logic [15:0] ans; int lat, rlo; logic err;
      mem_op(16'h0011, 16'hAA55, 1'b0, 1'b1, 1'b1, ans, lat, rlo, err);
      chk_cnt++;
      if (ans !== 16'h0011) $display("FAIL store_byte_ans: ans=%h want 0011", ans);
      else pass_cnt++;
      mem_op(16'h0010, 16'h0000, 1'b1, 1'b0, 1'b0, ans, lat, rlo, err);
      chk_cnt++;
      if (ans !== 16'hBE55) $display("FAIL merge_lo: ans=%h want BE55", ans);
      else pass_cnt++;
      mem_op(16'h0010, 16'h0000, 1'b1, 1'b0, 1'b1, ans, lat, rlo, err);
      chk_cnt++;
      if (ans !== 16'h00BE) $display("FAIL load_byte_hi: ans=%h want 00BE", ans);
      else pass_cnt++;
      mem_op(16'h0011, 16'h0000, 1'b1, 1'b0, 1'b1, ans, lat, rlo, err);
      chk_cnt++;
      if (ans !== 16'h0055) $display("FAIL load_byte_lo: ans=%h want 0055", ans);
      else pass_cnt++;
      mem_op(16'h0010, 16'h3412, 1'b0, 1'b1, 1'b1, ans, lat, rlo, err);
      mem_op(16'h0010, 16'h0000, 1'b1, 1'b0, 1'b0, ans, lat, rlo, err);
      chk_cnt++;
      if (ans !== 16'h1255) $display("FAIL merge_hi: ans=%h want 1255", ans);
      else pass_cnt++;
   endtask

   task automatic test_rd_wr_both();
      logic [15:0] ans; int lat, rlo; logic err;
      mem_op(16'h0030, 16'hCAFE, 1'b1, 1'b1, 1'b0, ans, lat, rlo, err);
      chk_cnt++;
      if (ans !== 16'h0030 || lat != 2) $display("FAIL rdwr_store: ans=%h lat=%0d want 0030/2", ans, lat);
      else pass_cnt++;
      mem_op(16'h0030, 16'h0000, 1'b1, 1'b0, 1'b0, ans, lat, rlo, err);
      chk_cnt++;
      if (ans !== 16'hCAFE) $display("FAIL rdwr_load: ans=%h want CAFE", ans);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_access();
      logic [15:0] ans; int lat, rlo; logic err;
      mem_op(16'h0020, 16'h1111, 1'b0, 1'b1, 1'b0, ans, lat, rlo, err);
      in_valid = 1'b1; alu_res = 16'h0020; st_data = 16'h2222; mem_wr = 1'b1;
      tick();
      in_valid = 1'b0; mem_wr = 1'b0;
      reset = 1'b0;
      tick();
      chk_cnt++;
      if (ans_dm !== 16'h0000 || out_valid !== 1'b0 || in_ready !== 1'b1 || mem_err !== 1'b0)
         $display("FAIL reset_mid: ans=%h ov=%b rdy=%b err=%b want 0000/0/1/0",
                  ans_dm, out_valid, in_ready, mem_err);
      else pass_cnt++;
      tick();
      reset = 1'b1;
      mem_op(16'h0020, 16'h0000, 1'b1, 1'b0, 1'b0, ans, lat, rlo, err);
      chk_cnt++;
      if (ans !== 16'h1111) $display("FAIL reset_nowrite: ans=%h want 1111", ans);
      else pass_cnt++;
   endtask

   task automatic test_wrap();
      logic [15:0] ans; int lat, rlo; logic err;
      mem_op(16'h0202, 16'hA5A5, 1'b0, 1'b1, 1'b0, ans, lat, rlo, err);
      chk_cnt++;
      if (ans !== 16'h0202) $display("FAIL wrap_store_ans: ans=%h want 0202", ans);
      else pass_cnt++;
      mem_op(16'h0002, 16'h0000, 1'b1, 1'b0, 1'b0, ans, lat, rlo, err);
      chk_cnt++;
      if (ans !== 16'hA5A5) $display("FAIL wrap_load: ans=%h want A5A5", ans);
      else pass_cnt++;
   endtask

`ifdef DMEM_PARITY_EN
   task automatic test_parity();
      logic [15:0] ans; int lat, rlo; logic err;
      mem_op(16'h000A, 16'h0F0F, 1'b0, 1'b1, 1'b0, ans, lat, rlo, err);
      force dut.u_ram.mem_q[5] = 17'h00F0E;
      mem_op(16'h000A, 16'h0000, 1'b1, 1'b0, 1'b0, ans, lat, rlo, err);
      chk_cnt++;
      if (err !== 1'b1 || ans !== 16'h0F0E) $display("FAIL parity_err: err=%b ans=%h want 1/0F0E", err, ans);
      else pass_cnt++;
      release dut.u_ram.mem_q[5];
      mem_op(16'h0010, 16'h0000, 1'b1, 1'b0, 1'b0, ans, lat, rlo, err);
      chk_cnt++;
      if (err !== 1'b0 || ans !== 16'h1255) $display("FAIL parity_clean: err=%b ans=%h want 0/1255", err, ans);
      else pass_cnt++;
   endtask
`endif

   initial begin
      test_reset();
      test_passthru();
      test_back_to_back();
      test_word();
      test_byte();
      test_rd_wr_both();
      test_reset_mid_access();
      test_wrap();
`ifdef DMEM_PARITY_EN
      test_parity();
`endif
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
